// File: rtl/anycore_l15_reqencoder.sv
// Request-side bridge from the anycore L1 caches to the L1.5 transducer.
// Holds one pending request per type and issues them one at a time, with store first, then load, then ifill.
module anycore_l15_reqencoder #(
  parameter int PADDR_WIDTH = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   anycore_ic2mem_reqvalid,
  input  logic [PADDR_WIDTH-1:0] anycore_ic2mem_reqaddr,
  input  logic                   anycore_dc2mem_ldvalid,
  input  logic [PADDR_WIDTH-1:0] anycore_dc2mem_ldaddr,
  input  logic                   anycore_dc2mem_stvalid,
  input  logic [PADDR_WIDTH-1:0] anycore_dc2mem_staddr,
  input  logic [63:0]            anycore_dc2mem_stdata,
  input  logic [1:0]             anycore_dc2mem_stsize,
  output logic                   transducer_l15_val,
  output logic [4:0]             transducer_l15_rqtype,
  output logic [PADDR_WIDTH-1:0] transducer_l15_address,
  output logic [63:0]            transducer_l15_data,
  output logic [2:0]             transducer_l15_size,
  output logic                   transducer_l15_nc,
  output logic                   transducer_l15_threadid,
  input  logic                   l15_transducer_ack,
  output logic                   err_overflow
);

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [4:0] IMISS_RQ = 5'b10000;

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef enum logic [1:0] {SEL_IC, SEL_LD, SEL_ST} sel_t;

  state_t state;
  sel_t   sel;

  logic                   ic_pend, ld_pend, st_pend;
  logic [PADDR_WIDTH-1:0] ic_addr, ld_addr, st_addr;
  logic [63:0]            st_data;
  logic [1:0]             st_size;

  logic issue_ack, clr_ic, clr_ld, clr_st;

  assign issue_ack = (state == ISSUE) && l15_transducer_ack;
  assign clr_ic    = issue_ack && (sel == SEL_IC);
  assign clr_ld    = issue_ack && (sel == SEL_LD);
  assign clr_st    = issue_ack && (sel == SEL_ST);

  assign transducer_l15_nc       = 1'b0;
  assign transducer_l15_threadid = 1'b0;

  function automatic logic [63:0] byte_swap(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = d[56-8*i +: 8];
    end
    return r;
  endfunction

  // A new pulse may refill a slot in the very cycle its ack empties it; otherwise a busy slot drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_pend      <= 1'b0;
      ld_pend      <= 1'b0;
      st_pend      <= 1'b0;
      ic_addr      <= '0;
      ld_addr      <= '0;
      st_addr      <= '0;
      st_data      <= '0;
      st_size      <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (anycore_ic2mem_reqvalid) begin
        if (!ic_pend || clr_ic) begin
          ic_pend <= 1'b1;
          ic_addr <= anycore_ic2mem_reqaddr;
        end else begin
          err_overflow <= 1'b1;
        end
      end else if (clr_ic) begin
        ic_pend <= 1'b0;
      end

      if (anycore_dc2mem_ldvalid) begin
        if (!ld_pend || clr_ld) begin
          ld_pend <= 1'b1;
          ld_addr <= anycore_dc2mem_ldaddr;
        end else begin
          err_overflow <= 1'b1;
        end
      end else if (clr_ld) begin
        ld_pend <= 1'b0;
      end

      if (anycore_dc2mem_stvalid) begin
        if (!st_pend || clr_st) begin
          st_pend <= 1'b1;
          st_addr <= anycore_dc2mem_staddr;
          st_data <= anycore_dc2mem_stdata;
          st_size <= anycore_dc2mem_stsize;
        end else begin
          err_overflow <= 1'b1;
        end
      end else if (clr_st) begin
        st_pend <= 1'b0;
      end
    end
  end

  // Selection happens only in IDLE, so a late higher-priority arrival never disturbs an issued request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      sel                    <= SEL_IC;
      transducer_l15_val     <= 1'b0;
      transducer_l15_rqtype  <= '0;
      transducer_l15_address <= '0;
      transducer_l15_data    <= '0;
      transducer_l15_size    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (st_pend) begin
            sel                    <= SEL_ST;
            transducer_l15_rqtype  <= STORE_RQ;
            transducer_l15_address <= st_addr;
            transducer_l15_data    <= byte_swap(st_data);
            transducer_l15_size    <= {1'b0, st_size} + 3'd1;
            transducer_l15_val     <= 1'b1;
            state                  <= ISSUE;
          end else if (ld_pend) begin
            sel                    <= SEL_LD;
            transducer_l15_rqtype  <= LOAD_RQ;
            transducer_l15_address <= {ld_addr[PADDR_WIDTH-1:4], 4'b0000};
            transducer_l15_data    <= '0;
            transducer_l15_size    <= 3'b000;
            transducer_l15_val     <= 1'b1;
            state                  <= ISSUE;
          end else if (ic_pend) begin
            sel                    <= SEL_IC;
            transducer_l15_rqtype  <= IMISS_RQ;
            transducer_l15_address <= {ic_addr[PADDR_WIDTH-1:5], 5'b00000};
            transducer_l15_data    <= '0;
            transducer_l15_size    <= 3'b000;
            transducer_l15_val     <= 1'b1;
            state                  <= ISSUE;
          end
        end
        ISSUE: begin
          if (l15_transducer_ack) begin
            transducer_l15_val <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_anycore_l15_reqencoder.sv
// Bench for anycore_l15_reqencoder: a request-level model is compared every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_anycore_l15_reqencoder;

  logic        clk;
  logic        rst;
  logic        ic_valid;
  logic [39:0] ic_addr;
  logic        ld_valid;
  logic [39:0] ld_addr;
  logic        st_valid;
  logic [39:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        ack;
  logic        val;
  logic [4:0]  rqtype;
  logic [39:0] address;
  logic [63:0] data;
  logic [2:0]  size;
  logic        nc;
  logic        threadid;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  anycore_l15_reqencoder #(.PADDR_WIDTH(40)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .anycore_ic2mem_reqvalid (ic_valid),
    .anycore_ic2mem_reqaddr  (ic_addr),
    .anycore_dc2mem_ldvalid  (ld_valid),
    .anycore_dc2mem_ldaddr   (ld_addr),
    .anycore_dc2mem_stvalid  (st_valid),
    .anycore_dc2mem_staddr   (st_addr),
    .anycore_dc2mem_stdata   (st_data),
    .anycore_dc2mem_stsize   (st_size),
    .transducer_l15_val      (val),
    .transducer_l15_rqtype   (rqtype),
    .transducer_l15_address  (address),
    .transducer_l15_data     (data),
    .transducer_l15_size     (size),
    .transducer_l15_nc       (nc),
    .transducer_l15_threadid (threadid),
    .l15_transducer_ack      (ack),
    .err_overflow            (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request-level model: slot index 0=ifill, 1=load, 2=store; highest index wins.
  bit          m_pend [3];
  logic [39:0] m_addr [3];
  logic [63:0] m_stdata;
  logic [1:0]  m_stsize;
  bit          m_busy;
  int          m_cur;
  logic        exp_val;
  logic [4:0]  exp_type;
  logic [39:0] exp_addr;
  logic [63:0] exp_data;
  logic [2:0]  exp_size;
  logic        exp_ovf;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 0;
      m_addr[k] = '0;
    end
    m_stdata = '0;
    m_stsize = '0;
    m_busy   = 0;
    m_cur    = 0;
    exp_val  = 0;
    exp_type = '0;
    exp_addr = '0;
    exp_data = '0;
    exp_size = '0;
    exp_ovf  = 0;
  endtask

  task automatic model_step();
    bit          clr [3];
    bit          pulse [3];
    logic [39:0] paddr [3];
    int          nbytes;
    if (rst) begin
      model_reset();
      return;
    end
    pulse = '{ic_valid, ld_valid, st_valid};
    paddr = '{ic_addr, ld_addr, st_addr};
    clr   = '{0, 0, 0};
    if (m_busy) begin
      if (ack) begin
        clr[m_cur] = 1;
        m_busy     = 0;
        exp_val    = 0;
      end
    end else begin
      for (int p = 2; p >= 0; p--) begin
        if (m_pend[p] && !m_busy) begin
          m_busy  = 1;
          m_cur   = p;
          exp_val = 1;
          case (p)
            0: begin
              exp_type = 5'b10000;
              exp_addr = m_addr[0] & ~40'h1F;
              exp_data = '0;
              exp_size = 3'd0;
            end
            1: begin
              exp_type = 5'b00000;
              exp_addr = m_addr[1] & ~40'hF;
              exp_data = '0;
              exp_size = 3'd0;
            end
            default: begin
              nbytes   = 1 << m_stsize;
              exp_type = 5'b00001;
              exp_addr = m_addr[2];
              exp_data = {<<8{m_stdata}};
              exp_size = 3'($clog2(nbytes) + 1);
            end
          endcase
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (pulse[k]) begin
        if (m_pend[k] && !clr[k]) begin
          exp_ovf = 1;
        end else begin
          m_pend[k] = 1;
          m_addr[k] = paddr[k];
          if (k == 2) begin
            m_stdata = st_data;
            m_stsize = st_size;
          end
        end
      end else if (clr[k]) begin
        m_pend[k] = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Model comparison on every falling edge outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("mdl_val", 64'(val), 64'(exp_val));
        checkOutput("mdl_ovf", 64'(ovf), 64'(exp_ovf));
        checkOutput("mdl_nc", 64'(nc), 64'd0);
        checkOutput("mdl_tid", 64'(threadid), 64'd0);
        if (exp_val) begin
          checkOutput("mdl_type", 64'(rqtype), 64'(exp_type));
          checkOutput("mdl_addr", 64'(address), 64'(exp_addr));
          checkOutput("mdl_data", data, exp_data);
          checkOutput("mdl_size", 64'(size), 64'(exp_size));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of pulses, then returns one ns into the following cycle.
  task automatic applyStimulus(input logic icv, input logic [39:0] ica,
                               input logic ldv, input logic [39:0] lda,
                               input logic stv, input logic [39:0] sta,
                               input logic [63:0] std, input logic [1:0] sts);
    ic_valid = icv;
    ic_addr  = ica;
    ld_valid = ldv;
    ld_addr  = lda;
    st_valid = stv;
    st_addr  = sta;
    st_data  = std;
    st_size  = sts;
    tick();
    ic_valid = 1'b0;
    ld_valid = 1'b0;
    st_valid = 1'b0;
  endtask

  task automatic wait_val(input string name);
    int n = 0;
    while (val !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (val !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: val actual %b required 1 within 20 cycles", name, val);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [4:0]  t3_type [3];
  logic [39:0] t3_addr [3];

  initial begin
    rst      = 1'b1;
    ack      = 1'b0;
    ic_valid = 1'b0;
    ic_addr  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_size  = '0;
    repeat (2) tick();
    checkOutput("rst_val", 64'(val), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    checkOutput("rst_addr", 64'(address), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] single store");
    applyStimulus(0, '0, 0, '0, 1, 40'h80_0000_0013, 64'h1122334455667788, 2'b10);
    checkOutput("t2_val_c1", 64'(val), 64'd0);
    tick();
    checkOutput("t2_val_c2", 64'(val), 64'd1);
    checkOutput("t2_type", 64'(rqtype), 64'h01);
    checkOutput("t2_size", 64'(size), 64'h3);
    checkOutput("t2_addr", 64'(address), 64'h80_0000_0013);
    checkOutput("t2_data", data, 64'h8877665544332211);
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput("t2_val_c5", 64'(val), 64'd0);
    repeat (2) tick();

    $display("[TB] simultaneous ifill, load, store");
    t3_type = '{5'b00001, 5'b00000, 5'b10000};
    t3_addr = '{40'h40_0000_0008, 40'h00_2000_0010, 40'h00_1000_0040};
    applyStimulus(1, 40'h00_1000_0047, 1, 40'h00_2000_0019, 1, 40'h40_0000_0008,
                  64'h0102030405060708, 2'b11);
    for (int i = 0; i < 3; i++) begin
      wait_val("t3_rise");
      checkOutput("t3_type", 64'(rqtype), 64'(t3_type[i]));
      checkOutput("t3_addr", 64'(address), 64'(t3_addr[i]));
      if (i == 0) begin
        checkOutput("t3_st_data", data, 64'h0807060504030201);
        checkOutput("t3_st_size", 64'(size), 64'h4);
      end
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checkOutput("t3_gap", 64'(val), 64'd0);
      if (i < 2) begin
        tick();
        checkOutput("t3_next_rise", 64'(val), 64'd1);
      end
    end
    repeat (2) tick();

    $display("[TB] load overflow");
    apply_reset();
    applyStimulus(0, '0, 1, 40'h00_5000_0023, 0, '0, '0, '0);
    tick();
    tick();
    applyStimulus(0, '0, 1, 40'h00_6000_0000, 0, '0, '0, '0);
    checkOutput("t4_ovf", 64'(ovf), 64'd1);
    checkOutput("t4_addr", 64'(address), 64'h00_5000_0020);
    repeat (3) tick();
    checkOutput("t4_ovf_sticky", 64'(ovf), 64'd1);
    checkOutput("t4_addr_held", 64'(address), 64'h00_5000_0020);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (3) tick();
    checkOutput("t4_no_reissue", 64'(val), 64'd0);
    checkOutput("t4_ovf_after", 64'(ovf), 64'd1);

    $display("[TB] async reset mid-issue");
    applyStimulus(0, '0, 0, '0, 1, 40'h00_0000_0100, 64'hFFEEDDCCBBAA9988, 2'b01);
    wait_val("t1_rise");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t1_val", 64'(val), 64'd0);
    checkOutput("t1_type", 64'(rqtype), 64'd0);
    checkOutput("t1_addr", 64'(address), 64'd0);
    checkOutput("t1_data", data, 64'd0);
    checkOutput("t1_size", 64'(size), 64'd0);
    checkOutput("t1_ovf", 64'(ovf), 64'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("t1_discarded", 64'(val), 64'd0);

    $display("[TB] capture on clear");
    apply_reset();
    applyStimulus(0, '0, 1, 40'h00_7000_0005, 0, '0, '0, '0);
    wait_val("t5_rise1");
    tick();
    ack = 1'b1;
    applyStimulus(0, '0, 1, 40'h00_3000_0000, 0, '0, '0, '0);
    ack = 1'b0;
    checkOutput("t5_gap", 64'(val), 64'd0);
    tick();
    checkOutput("t5_val2", 64'(val), 64'd1);
    checkOutput("t5_addr2", 64'(address), 64'h00_3000_0000);
    checkOutput("t5_ovf", 64'(ovf), 64'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (2) tick();

    $display("[TB] no preemption");
    apply_reset();
    applyStimulus(1, 40'h00_1234_5678, 0, '0, 0, '0, '0, '0);
    wait_val("t6_rise");
    tick();
    applyStimulus(0, '0, 0, '0, 1, 40'h00_0000_0abc, 64'h00000000000000AA, 2'b00);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t6_held_val", 64'(val), 64'd1);
      checkOutput("t6_held_type", 64'(rqtype), 64'h10);
      checkOutput("t6_held_addr", 64'(address), 64'h00_1234_5660);
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput("t6_gap", 64'(val), 64'd0);
    tick();
    checkOutput("t6_st_val", 64'(val), 64'd1);
    checkOutput("t6_st_type", 64'(rqtype), 64'h01);
    checkOutput("t6_st_data", data, 64'hAA00000000000000);
    checkOutput("t6_st_size", 64'(size), 64'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
